anc_lms_sequencer: RTL and testbench
====================================

Name: anc_lms_sequencer

Overview:
Control stage directly upstream and downstream of the adaptive FIR weight block in the ANC datapath.
- Accepts paired reference-mic and error-mic samples from the ADC front end.
- Forms the LMS step (weight_adjust) and the FIR input (feedforward_in), issues a one-cycle go, then waits for done.
- Saturates the FIR result to a 16-bit DAC anti-noise sample.
- Provides a one-deep pending buffer for sample frames, plus overrun and timeout detection.

Parameters:
FRAC, 15, fractional bits of the Q-format used by the FIR; also the shift applied to mu*err.
TAPS, 128, FIR tap count; used only to size the timeout default.
TIMEOUT, 256, cycles allowed between go and fir_done before abort (must be > TAPS+3).
OUT_W, 16, DAC sample width.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
smp_valid  in  1  one-cycle strobe: ref_sample/err_sample valid
ref_sample  in  16  signed Q1.15 reference-mic sample
err_sample  in  16  signed Q1.15 error-mic sample
mu  in  16  unsigned Q0.15 step size; sampled at launch
adapt_en  in  1  0 forces weight_adjust to 0 (filter frozen); sampled at launch
feedforward_in  out  32  to FIR: sign-extended ref_sample
weight_adjust  out  32  to FIR: LMS step
go  out  1  to FIR: one-cycle start pulse
fir_out  in  32  from FIR out_sample
fir_valid  in  1  from FIR out_valid
fir_done  in  1  from FIR done
dac_sample  out  16  saturated anti-noise sample
dac_valid  out  1  one-cycle strobe with dac_sample
busy  out  1  high in any state except IDLE
overrun  out  1  sticky; frame dropped; cleared only by reset
timeout  out  1  sticky; FIR did not finish; cleared only by reset

Behaviour:
- Reset (async, rst_n low): all outputs 0; state IDLE; pending buffer empty; counters 0. Reset mid-operation aborts immediately. The FIR shares rst_n.
- States: IDLE, LAUNCH, WAIT, EMIT.
- IDLE:
  - Current frame = smp_valid frame, else the pending frame.
  - On either source: register ref/err/mu/adapt_en into working regs; go to LAUNCH.
- LAUNCH (1 cycle):
  - go=1.
  - feedforward_in = sign-extend(ref) to 32.
  - weight_adjust = adapt_en ? -((mu_zext * err_sext) >>> FRAC) : 0. Product is signed 32-bit (mu zero-extended to 17 bits).
  - Next state WAIT; timeout counter cleared.
- feedforward_in and weight_adjust are held constant from LAUNCH until the next LAUNCH. The FIR reads weight_adjust on every tap cycle.
- WAIT:
  - Counter increments each cycle.
  - fir_done (with fir_valid): capture fir_out; go to EMIT.
  - Counter reaches TIMEOUT-1 without done: set timeout; go to IDLE; no dac_valid.
- EMIT (1 cycle):
  - dac_valid=1.
  - dac_sample = fir_out clamped to [-32768, 32767]: >32767 gives 0x7FFF; < -32768 gives 0x8000.
  - Next state IDLE. The pending frame is launched from IDLE on the following cycle.
- Latency: smp_valid in IDLE to go = 2 cycles. fir_done to dac_valid = 1 cycle.
- Pending buffer (depth 1):
  - smp_valid while busy: store the frame in pending if empty.
  - If pending is already full: drop the new frame, set overrun; the pending frame is kept.
- Simultaneous events:
  - smp_valid in the same cycle pending is consumed in IDLE: launch the pending (older) frame and store the new one in pending.
  - fir_done on the same cycle as the timeout limit: done wins, no timeout.
- fir_done outside WAIT is ignored.
- go is never asserted outside LAUNCH and is never held for more than 1 cycle.

Decomposition:
- Package anc_pkg: FRAC, OUT_W, Q-format widths, state enum encoding, saturation bounds (SAT_MAX=32767, SAT_MIN=-32768).
- Sub-module anc_sat: combinational 32-to-OUT_W signed saturator, reused by later output stages.
- Sequencer FSM, pending buffer and timeout counter stay in anc_lms_sequencer.

Test Plan:
- Basic adapt:
  - Stimulus: ref=0x4000, err=0x2000, mu=0x0800, adapt_en=1; stub FIR returns done after 131 cycles with fir_out=0x00001234.
  - Response: go 2 cycles after smp_valid; feedforward_in=0x00004000; weight_adjust=-(0x800*0x2000>>>15) = 0xFFFFFE00; dac_sample=0x1234 one cycle after done.
- Freeze: same frame with adapt_en=0 -> weight_adjust=0; dac_valid still issued.
- Saturation:
  - fir_out=0x00012345 -> dac_sample=0x7FFF.
  - fir_out=0xFFFE0000 -> dac_sample=0x8000.
- Back-pressure:
  - Frames A, B, C during one WAIT -> A processed, B pending then launched after EMIT, C dropped, overrun=1, exactly two dac_valid pulses.
- Timeout: FIR stub never asserts done -> timeout=1 at go+256 cycles, state IDLE, no dac_valid; the next frame processes normally.
- Reset mid-WAIT: rst_n low for 3 cycles -> all outputs 0, busy=0, pending cleared, sticky flags cleared; no go until a new smp_valid.

Source files
------------

// File: rtl/anc_pkg.sv
// Shared constants and types for the ANC LMS control path:
// Q1.15 mic samples, Q0.15 step size, 32-bit FIR accumulator domain.
package anc_pkg;
  localparam int FRAC    = 15;
  localparam int OUT_W   = 16;
  localparam int SMP_W   = 16;
  localparam int MU_W    = 16;
  localparam int ACC_W   = 32;
  localparam int SAT_MAX = 32767;
  localparam int SAT_MIN = -32768;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_EMIT   = 2'd3
  } state_t;

  typedef struct packed {
    logic [SMP_W-1:0] ref_s;
    logic [SMP_W-1:0] err_s;
    logic [MU_W-1:0]  mu;
    logic             adapt_en;
  } frame_t;
endpackage

// File: rtl/anc_sat.sv
// Purpose: signed saturator from IN_W down to OUT_W bits.
// Latency: combinational.
// Backpressure: none; pure function of din.
module anc_sat #(
  parameter int IN_W  = anc_pkg::ACC_W,
  parameter int OUT_W = anc_pkg::OUT_W
) (
  input  logic [IN_W-1:0]  din,
  output logic [OUT_W-1:0] dout
);
  localparam logic signed [IN_W-1:0] MAX_V = IN_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  localparam logic signed [IN_W-1:0] MIN_V = ~MAX_V;

  logic signed [IN_W-1:0] din_s;

  assign din_s = din;

  always_comb begin
    if (din_s > MAX_V) begin
      dout = MAX_V[OUT_W-1:0];
    end else if (din_s < MIN_V) begin
      dout = MIN_V[OUT_W-1:0];
    end else begin
      dout = din_s[OUT_W-1:0];
    end
  end
endmodule

// File: rtl/anc_lms_sequencer.sv
// Purpose: launches one adaptive-FIR pass per mic frame and saturates the result for the DAC.
// Latency: smp_valid to go 2 cycles (input register + IDLE); fir_done to dac_valid 1 cycle.
// Backpressure: none upstream; one frame is buffered while busy, later ones are dropped and flag overrun.
module anc_lms_sequencer #(
  parameter int FRAC    = anc_pkg::FRAC,
  parameter int TAPS    = 128,
  parameter int TIMEOUT = 2 * TAPS,
  parameter int OUT_W   = anc_pkg::OUT_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      smp_valid,
  input  logic [anc_pkg::SMP_W-1:0] ref_sample,
  input  logic [anc_pkg::SMP_W-1:0] err_sample,
  input  logic [anc_pkg::MU_W-1:0]  mu,
  input  logic                      adapt_en,
  output logic [anc_pkg::ACC_W-1:0] feedforward_in,
  output logic [anc_pkg::ACC_W-1:0] weight_adjust,
  output logic                      go,
  input  logic [anc_pkg::ACC_W-1:0] fir_out,
  input  logic                      fir_valid,
  input  logic                      fir_done,
  output logic [OUT_W-1:0]          dac_sample,
  output logic                      dac_valid,
  output logic                      busy,
  output logic                      overrun,
  output logic                      timeout
);
  import anc_pkg::*;

  localparam int CNT_W = $clog2(TIMEOUT);

  state_t                  state, state_nxt;
  frame_t                  in_frm, pend, wrk, sel_frm;
  logic                    in_vld, pend_vld, take, done_hit, cnt_last;
  logic [CNT_W-1:0]        cnt;
  logic [ACC_W-1:0]        fir_q;
  logic signed [ACC_W-1:0] mu_ext, err_ext, prod, step;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_vld <= 1'b0;
      in_frm <= '0;
    end else begin
      in_vld <= smp_valid;
      if (smp_valid) begin
        in_frm <= '{ref_s: ref_sample, err_s: err_sample, mu: mu, adapt_en: adapt_en};
      end
    end
  end

  assign done_hit = fir_done & fir_valid;
  assign cnt_last = (cnt == CNT_W'(TIMEOUT - 1));
  assign take     = (state == ST_IDLE) && (pend_vld || in_vld);
  // The buffered frame is always older than the one arriving, so it launches first.
  assign sel_frm  = pend_vld ? pend : in_frm;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (take) state_nxt = ST_LAUNCH;
      ST_LAUNCH: state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (done_hit) begin
          state_nxt = ST_EMIT;
        end else if (cnt_last) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_EMIT:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    go        = 1'b0;
    dac_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      ST_IDLE:   busy = 1'b0;
      ST_LAUNCH: go = 1'b1;
      ST_EMIT:   dac_valid = 1'b1;
      default:   ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrk      <= '0;
      pend     <= '0;
      pend_vld <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (take) begin
        wrk <= sel_frm;
      end
      if (take && pend_vld) begin
        pend     <= in_frm;
        pend_vld <= in_vld;
      end else if (in_vld && (state != ST_IDLE)) begin
        if (!pend_vld) begin
          pend     <= in_frm;
          pend_vld <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end
    end
  end

  // Counter starts with go, so the abort lands TIMEOUT cycles after the launch pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      fir_q   <= '0;
      timeout <= 1'b0;
    end else begin
      if (state == ST_IDLE) begin
        cnt <= '0;
      end else if (state != ST_EMIT) begin
        cnt <= cnt + CNT_W'(1);
      end
      if ((state == ST_WAIT) && done_hit) begin
        fir_q <= fir_out;
      end
      if ((state == ST_WAIT) && !done_hit && cnt_last) begin
        timeout <= 1'b1;
      end
    end
  end

  // FIR operands come straight from the working frame, so they hold until the next launch.
  assign mu_ext         = {{(ACC_W-MU_W){1'b0}}, wrk.mu};
  assign err_ext        = {{(ACC_W-SMP_W){wrk.err_s[SMP_W-1]}}, wrk.err_s};
  assign prod           = mu_ext * err_ext;
  assign step           = prod >>> FRAC;
  assign feedforward_in = {{(ACC_W-SMP_W){wrk.ref_s[SMP_W-1]}}, wrk.ref_s};
  assign weight_adjust  = wrk.adapt_en ? -step : '0;

  anc_sat #(
    .IN_W (ACC_W),
    .OUT_W(OUT_W)
  ) u_sat (
    .din (fir_q),
    .dout(dac_sample)
  );
endmodule

// File: tb/tb_anc_lms_sequencer.sv
// Directed bench for anc_lms_sequencer with an in-line FIR stub driven from the stimulus sequence.
module tb_anc_lms_sequencer;
  logic        clk;
  logic        rst_n;
  logic        smp_valid;
  logic [15:0] ref_sample, err_sample, mu;
  logic        adapt_en;
  logic [31:0] feedforward_in, weight_adjust, fir_out;
  logic        go, fir_valid, fir_done;
  logic [15:0] dac_sample;
  logic        dac_valid, busy, overrun, timeout;

  int n_tests = 0;
  int n_fail  = 0;
  int go_cnt  = 0;
  int dac_cnt = 0;
  int go0, dac0;

  anc_lms_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .smp_valid     (smp_valid),
    .ref_sample    (ref_sample),
    .err_sample    (err_sample),
    .mu            (mu),
    .adapt_en      (adapt_en),
    .feedforward_in(feedforward_in),
    .weight_adjust (weight_adjust),
    .go            (go),
    .fir_out       (fir_out),
    .fir_valid     (fir_valid),
    .fir_done      (fir_done),
    .dac_sample    (dac_sample),
    .dac_valid     (dac_valid),
    .busy          (busy),
    .overrun       (overrun),
    .timeout       (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (go === 1'b1) go_cnt <= go_cnt + 1;
    if (dac_valid === 1'b1) dac_cnt <= dac_cnt + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h required 0x%08h", tag, obs, expv);
    end
  endtask

  task automatic send(input logic [15:0] r, input logic [15:0] e, input logic [15:0] m, input logic en);
    ref_sample = r;
    err_sample = e;
    mu         = m;
    adapt_en   = en;
    smp_valid  = 1'b1;
    tick(1);
    smp_valid  = 1'b0;
  endtask

  // Leaves the bench at the negedge inside the go cycle.
  task automatic launch(input logic [15:0] r, input logic [15:0] e, input logic [15:0] m, input logic en);
    send(r, e, m, en);
    tick(1);
  endtask

  // Leaves the bench at the negedge inside the cycle after done (EMIT).
  task automatic fir_finish(input int dly, input logic [31:0] val);
    tick(dly);
    fir_out   = val;
    fir_done  = 1'b1;
    fir_valid = 1'b1;
    tick(1);
    fir_done  = 1'b0;
    fir_valid = 1'b0;
  endtask

  task automatic vec(input string tag, input logic [15:0] r, input logic [15:0] e, input logic [15:0] m,
                     input logic [31:0] ff_exp, input logic [31:0] wa_exp,
                     input logic [31:0] fo, input logic [15:0] dac_exp);
    launch(r, e, m, 1'b1);
    chk({tag, "_go"}, 32'(go), 32'd1);
    chk({tag, "_ff"}, feedforward_in, ff_exp);
    chk({tag, "_wa"}, weight_adjust, wa_exp);
    fir_finish(3, fo);
    chk({tag, "_dacv"}, 32'(dac_valid), 32'd1);
    chk({tag, "_dac"}, 32'(dac_sample), 32'(dac_exp));
    tick(1);
  endtask

  initial begin
    rst_n = 1'b0; smp_valid = 1'b0; ref_sample = '0; err_sample = '0; mu = '0;
    adapt_en = 1'b0; fir_out = '0; fir_valid = 1'b0; fir_done = 1'b0;
    tick(2);
    chk("rst_go", 32'(go), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_dacv", 32'(dac_valid), 32'd0);
    chk("rst_flags", {30'd0, overrun, timeout}, 32'd0);
    chk("rst_ff", feedforward_in, 32'd0);
    chk("rst_wa", weight_adjust, 32'd0);
    chk("rst_dac", 32'(dac_sample), 32'd0);
    rst_n = 1'b1;
    tick(1);

    // Basic adapt: go two cycles after the strobe, done after 131 cycles.
    send(16'h4000, 16'h2000, 16'h0800, 1'b1);
    chk("basic_go_early", 32'(go), 32'd0);
    tick(1);
    chk("basic_go", 32'(go), 32'd1);
    chk("basic_ff", feedforward_in, 32'h0000_4000);
    chk("basic_wa", weight_adjust, 32'hFFFF_FE00);
    chk("basic_busy", 32'(busy), 32'd1);
    tick(1);
    chk("basic_go_single", 32'(go), 32'd0);
    fir_finish(130, 32'h0000_1234);
    chk("basic_dacv", 32'(dac_valid), 32'd1);
    chk("basic_dac", 32'(dac_sample), 32'h1234);
    tick(1);
    chk("basic_dacv_end", 32'(dac_valid), 32'd0);
    chk("basic_idle", 32'(busy), 32'd0);

    // Frozen filter.
    launch(16'h4000, 16'h2000, 16'h0800, 1'b0);
    chk("frz_ff", feedforward_in, 32'h0000_4000);
    chk("frz_wa", weight_adjust, 32'd0);
    fir_finish(5, 32'h0000_0100);
    chk("frz_dacv", 32'(dac_valid), 32'd1);
    chk("frz_dac", 32'(dac_sample), 32'h0100);
    tick(1);

    // Step arithmetic (incl. floor on negative products) and saturation bounds.
    vec("v1", 16'hC000, 16'hE000, 16'h0800, 32'hFFFF_C000, 32'h0000_0200, 32'h0001_2345, 16'h7FFF);
    vec("v2", 16'h7FFF, 16'h8000, 16'hFFFF, 32'h0000_7FFF, 32'h0000_FFFF, 32'hFFFE_0000, 16'h8000);
    vec("v3", 16'h8000, 16'h0567, 16'h1234, 32'hFFFF_8000, 32'hFFFF_FF3C, 32'h0000_7FFF, 16'h7FFF);
    vec("v4", 16'h0001, 16'hFA99, 16'h1234, 32'h0000_0001, 32'h0000_00C5, 32'hFFFF_8000, 16'h8000);
    vec("v5", 16'h1234, 16'h0000, 16'h7FFF, 32'h0000_1234, 32'h0000_0000, 32'h0000_8000, 16'h7FFF);
    vec("v6", 16'hFFFF, 16'h7FFF, 16'h0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_7FFF, 16'h8000);
    vec("v7", 16'h0100, 16'h0001, 16'h8000, 32'h0000_0100, 32'hFFFF_FFFF, 32'hFFFF_FF00, 16'hFF00);

    // Done on the same cycle as the timeout limit: done wins.
    launch(16'h0010, 16'h0010, 16'h0010, 1'b1);
    fir_finish(255, 32'h0000_0055);
    chk("lim_dacv", 32'(dac_valid), 32'd1);
    chk("lim_dac", 32'(dac_sample), 32'h0055);
    chk("lim_timeout", 32'(timeout), 32'd0);
    tick(1);

    // fir_done while idle is ignored.
    fir_finish(1, 32'h0000_7777);
    chk("idle_done_busy", 32'(busy), 32'd0);
    chk("idle_done_dacv", 32'(dac_valid), 32'd0);
    tick(1);
    chk("idle_done_dac", 32'(dac_sample), 32'h0055);

    // Back-pressure: A runs, B waits in pending, C is dropped.
    go0 = go_cnt; dac0 = dac_cnt;
    launch(16'h0AAA, 16'h0100, 16'h0800, 1'b1);
    chk("bp_a_wa", weight_adjust, 32'hFFFF_FFF0);
    tick(1);
    send(16'h0BBB, 16'h0200, 16'h0800, 1'b1);
    send(16'h0CCC, 16'h0300, 16'h0800, 1'b1);
    tick(2);
    chk("bp_overrun", 32'(overrun), 32'd1);
    chk("bp_ff_held", feedforward_in, 32'h0000_0AAA);
    fir_finish(2, 32'h0000_0111);
    chk("bp_a_dac", 32'(dac_sample), 32'h0111);
    tick(1);
    chk("bp_gap_go", 32'(go), 32'd0);
    tick(1);
    chk("bp_b_go", 32'(go), 32'd1);
    chk("bp_b_ff", feedforward_in, 32'h0000_0BBB);
    chk("bp_b_wa", weight_adjust, 32'hFFFF_FFE0);
    fir_finish(4, 32'h0000_0222);
    chk("bp_b_dac", 32'(dac_sample), 32'h0222);
    tick(4);
    chk("bp_dac_pulses", 32'(dac_cnt - dac0), 32'd2);
    chk("bp_go_pulses", 32'(go_cnt - go0), 32'd2);
    chk("bp_idle", 32'(busy), 32'd0);
    chk("bp_c_never", feedforward_in, 32'h0000_0BBB);

    // Timeout: no done, abort 256 cycles after go.
    dac0 = dac_cnt;
    launch(16'h0020, 16'h0020, 16'h0020, 1'b1);
    tick(255);
    chk("to_early", 32'(timeout), 32'd0);
    chk("to_busy_early", 32'(busy), 32'd1);
    tick(1);
    chk("to_flag", 32'(timeout), 32'd1);
    chk("to_idle", 32'(busy), 32'd0);
    tick(2);
    chk("to_no_dac", 32'(dac_cnt - dac0), 32'd0);
    launch(16'h0030, 16'h0040, 16'h0800, 1'b1);
    chk("to_next_go", 32'(go), 32'd1);
    fir_finish(10, 32'h0000_0042);
    chk("to_next_dacv", 32'(dac_valid), 32'd1);
    chk("to_next_dac", 32'(dac_sample), 32'h0042);
    tick(1);

    // Reset mid-WAIT with a frame pending.
    launch(16'h0123, 16'h0000, 16'h0000, 1'b1);
    tick(1);
    send(16'h0456, 16'h0100, 16'h0800, 1'b1);
    tick(1);
    rst_n = 1'b0;
    #1;
    chk("mrst_go", 32'(go), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_dacv", 32'(dac_valid), 32'd0);
    chk("mrst_overrun", 32'(overrun), 32'd0);
    chk("mrst_timeout", 32'(timeout), 32'd0);
    chk("mrst_ff", feedforward_in, 32'd0);
    chk("mrst_wa", weight_adjust, 32'd0);
    chk("mrst_dac", 32'(dac_sample), 32'd0);
    go0 = go_cnt;
    tick(3);
    rst_n = 1'b1;
    tick(6);
    chk("mrst_no_go", 32'(go_cnt - go0), 32'd0);
    chk("mrst_idle", 32'(busy), 32'd0);
    launch(16'h0321, 16'h0100, 16'h0800, 1'b1);
    chk("mrst_new_ff", feedforward_in, 32'h0000_0321);
    chk("mrst_new_wa", weight_adjust, 32'hFFFF_FFF0);
    fir_finish(2, 32'hFFFF_FFF6);
    chk("mrst_new_dac", 32'(dac_sample), 32'hFFF6);
    tick(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
